// File: rtl/pwm_pkg.sv
// Shared constants, types and helpers for the multi-channel PWM peripheral.
package pwm_pkg;

  localparam int DEF_NUM_CH  = 16;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_PRESC_W = 8;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Largest duty/counter value representable in cnt_w bits.
  function automatic int pwm_max(input int cnt_w);
    return (1 << cnt_w) - 1;
  endfunction

endpackage

// File: rtl/pwm_multi_channel_if.sv
// Duty-register write bus between the SPI register block and the PWM core.
interface pwm_multi_channel_if
  import pwm_pkg::*;
#(
  parameter int ADDR_W = $clog2(DEF_NUM_CH),
  parameter int CNT_W  = DEF_CNT_W
) ();

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [CNT_W-1:0]  wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);

endinterface

// File: rtl/pwm_prescaler.sv
// Clock-enable generator: one tick every (prescale+1) clk cycles.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PRESC_W-1:0] prescale,
  output logic               tick
);

  localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);

  logic [PRESC_W-1:0] presc_cnt;

  // Using >= means lowering prescale below the running count ticks at once instead of wrapping.
  assign tick = (presc_cnt >= prescale);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt <= '0;
    end else if (tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + PRESC_ONE;
    end
  end

endmodule

// File: rtl/pwm_multi_channel.sv
// NUM_CH-channel PWM with a shared prescaled counter and double-buffered duty registers.
// Optional build macro: PWM_CENTER_ALIGNED_EN selects an up/down (centre-aligned) counter.
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int PRESC_W = DEF_PRESC_W,
  parameter int ADDR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PRESC_W-1:0]  prescale,
  pwm_multi_channel_if.slave  wr_bus,
  input  logic [NUM_CH-1:0]   en_out,
  input  logic [NUM_CH-1:0]   en_pwm,
  output logic [NUM_CH-1:0]   pwm_out,
  output logic                period_start
);

  localparam logic [CNT_W-1:0]  CNT_TOP  = CNT_W'(pwm_max(CNT_W) - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W:0]   NUM_CH_L = (ADDR_W + 1)'(NUM_CH);

  logic              tick;
  logic              wrap;
  logic              wr_hit;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  staging [NUM_CH];
  logic [CNT_W-1:0]  shadow  [NUM_CH];
  logic [NUM_CH-1:0] pwm_raw;

  pwm_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk      (clk),
    .rst      (rst),
    .prescale (prescale),
    .tick     (tick)
  );

`ifdef PWM_CENTER_ALIGNED_EN
  dir_e             dir;
  dir_e             dir_next;
  logic [CNT_W-1:0] cnt_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      dir <= DIR_UP;
      cnt <= '0;
    end else begin
      dir <= dir_next;
      cnt <= cnt_next;
    end
  end

  // Each endpoint is visited once: the turn-around tick already moves one step the other way.
  always_comb begin
    dir_next = dir;
    cnt_next = cnt;
    if (tick) begin
      case (dir)
        DIR_UP: begin
          if (cnt == CNT_TOP) begin
            dir_next = DIR_DOWN;
            cnt_next = cnt - CNT_ONE;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end
        DIR_DOWN: begin
          if (cnt == CNT_ONE) begin
            dir_next = DIR_UP;
            cnt_next = '0;
          end else begin
            cnt_next = cnt - CNT_ONE;
          end
        end
        default: begin
          dir_next = DIR_UP;
          cnt_next = '0;
        end
      endcase
    end
  end

  always_comb begin
    wrap = tick && (dir == DIR_DOWN) && (cnt == CNT_ONE);
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= (cnt == CNT_TOP) ? '0 : cnt + CNT_ONE;
    end
  end

  assign wrap = tick && (cnt == CNT_TOP);
`endif

  assign wr_hit = wr_bus.wr_en && ({1'b0, wr_bus.wr_addr} < NUM_CH_L);

  // Shadows copy the pre-edge staging values, so a write landing on the wrap edge waits a full period.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        staging[i] <= '0;
        shadow[i]  <= '0;
      end
    end else begin
      if (wrap) begin
        for (int i = 0; i < NUM_CH; i++) begin
          shadow[i] <= staging[i];
        end
      end
      if (wr_hit) begin
        staging[wr_bus.wr_addr] <= wr_bus.wr_data;
      end
    end
  end

  always_comb begin
    pwm_raw = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pwm_raw[i] = (cnt < shadow[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_out      <= '0;
      period_start <= 1'b0;
    end else begin
      pwm_out      <= en_out & (~en_pwm | pwm_raw);
      period_start <= wrap;
    end
  end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Self-checking bench for pwm_multi_channel against a tick-count reference model.
// Also exercises the PWM_CENTER_ALIGNED_EN build when that macro is defined.
module tb_pwm_multi_channel;

  localparam int NUM_CH  = 12;
  localparam int CNT_W   = 8;
  localparam int PRESC_W = 8;
  localparam int ADDR_W  = 4;
  localparam int MAXV    = (1 << CNT_W) - 1;
`ifdef PWM_CENTER_ALIGNED_EN
  localparam int PERIOD  = 2 * (MAXV - 1);
`else
  localparam int PERIOD  = MAXV;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [PRESC_W-1:0] prescale = '0;
  logic [NUM_CH-1:0]  en_out = '0;
  logic [NUM_CH-1:0]  en_pwm = '0;
  logic [NUM_CH-1:0]  pwm_out;
  logic               period_start;

  int checks;
  int errors;

  pwm_multi_channel_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) wr_bus ();

  pwm_multi_channel #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .PRESC_W (PRESC_W),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .prescale     (prescale),
    .wr_bus       (wr_bus),
    .en_out       (en_out),
    .en_pwm       (en_pwm),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  // Reference model: counter value derived from the number of ticks since reset.
  int               m_pdiv;
  int               m_ticks;
  int               m_stage  [NUM_CH];
  int               m_shadow [NUM_CH];
  logic [NUM_CH-1:0] m_pwm;
  logic             m_ps;

  function automatic int cnt_of(input int t);
    int p;
    p = t % PERIOD;
`ifdef PWM_CENTER_ALIGNED_EN
    return (p <= MAXV - 1) ? p : PERIOD - p;
`else
    return p;
`endif
  endfunction

  function automatic int exp_highs(input int d);
`ifdef PWM_CENTER_ALIGNED_EN
    if (d == 0) return 0;
    return (2 * d - 1 > PERIOD) ? PERIOD : 2 * d - 1;
`else
    return d;
`endif
  endfunction

  function automatic bit wrap_next();
    return (m_pdiv >= int'(prescale)) && (((m_ticks + 1) % PERIOD) == 0);
  endfunction

  always @(posedge clk) begin : model
    bit tk;
    bit wr;
    int c;
    if (rst) begin
      m_pdiv  = 0;
      m_ticks = 0;
      m_pwm   = '0;
      m_ps    = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_stage[i]  = 0;
        m_shadow[i] = 0;
      end
    end else begin
      tk = (m_pdiv >= int'(prescale));
      c  = cnt_of(m_ticks);
      wr = tk && (((m_ticks + 1) % PERIOD) == 0);
      for (int i = 0; i < NUM_CH; i++) begin
        m_pwm[i] = en_out[i] && (!en_pwm[i] || (c < m_shadow[i]));
      end
      m_ps = wr;
      if (wr) m_shadow = m_stage;
      if (wr_bus.wr_en && int'(wr_bus.wr_addr) < NUM_CH) begin
        m_stage[int'(wr_bus.wr_addr)] = int'(wr_bus.wr_data);
      end
      m_pdiv = tk ? 0 : m_pdiv + 1;
      if (tk) m_ticks++;
    end
  end

  task automatic apply_write(input int ch, input int d);
    wr_bus.wr_en   = 1'b1;
    wr_bus.wr_addr = ADDR_W'(ch);
    wr_bus.wr_data = CNT_W'(d);
    @(negedge clk);
    wr_bus.wr_en   = 1'b0;
  endtask

  task automatic test_reset();
    bit found;
    rst = 1'b1;
    en_out = '1;
    en_pwm = '0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checks++;
      if (pwm_out !== '0 || period_start !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_initial pwm_out=%h period_start=%b, wanted 0/0", pwm_out, period_start);
      end
    end
    rst = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      checks++;
      if (pwm_out !== m_pwm || period_start !== m_ps) begin
        errors++;
        $display("[TB] FAIL pre_reset t=%0t pwm_out=%h exp=%h ps=%b exp=%b", $time, pwm_out, m_pwm, period_start, m_ps);
      end
    end
    rst = 1'b1;
    wr_bus.wr_en   = 1'b1;
    wr_bus.wr_addr = ADDR_W'(2);
    wr_bus.wr_data = CNT_W'(200);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      wr_bus.wr_en = 1'b0;
      checks++;
      if (pwm_out !== '0 || period_start !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_hold pwm_out=%h period_start=%b, wanted 0/0", pwm_out, period_start);
      end
    end
    rst = 1'b0;
    en_pwm = '1;
    found = 1'b0;
    for (int n = 1; n <= PERIOD + 5; n++) begin
      @(negedge clk);
      checks++;
      if (pwm_out !== m_pwm || period_start !== m_ps) begin
        errors++;
        $display("[TB] FAIL post_reset t=%0t pwm_out=%h exp=%h ps=%b exp=%b", $time, pwm_out, m_pwm, period_start, m_ps);
      end
      if (period_start === 1'b1) begin
        found = 1'b1;
        checks++;
        if (n != PERIOD) begin
          errors++;
          $display("[TB] FAIL first_boundary got cycle %0d, wanted %0d", n, PERIOD);
        end
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("[TB] FAIL first_boundary no period_start within %0d cycles", PERIOD + 5);
    end
  endtask

  task automatic test_duty_sweep();
    int duties [4] = '{0, 1, 128, 255};
    int seen;
    int highs;
    prescale = '0;
    en_out = '1;
    en_pwm = '1;
    foreach (duties[k]) begin
      apply_write(0, duties[k]);
      seen = 0;
      for (int n = 0; n < 3 * PERIOD && seen < 2; n++) begin
        @(negedge clk);
        checks++;
        if (pwm_out !== m_pwm || period_start !== m_ps) begin
          errors++;
          $display("[TB] FAIL sweep_model t=%0t pwm_out=%h exp=%h ps=%b exp=%b", $time, pwm_out, m_pwm, period_start, m_ps);
        end
        if (period_start === 1'b1) seen++;
      end
      checks++;
      if (seen != 2) begin
        errors++;
        $display("[TB] FAIL sweep_boundary saw %0d period_start pulses, wanted 2", seen);
      end
      highs = 0;
      for (int n = 0; n < PERIOD; n++) begin
        @(negedge clk);
        checks++;
        if (pwm_out !== m_pwm || period_start !== m_ps) begin
          errors++;
          $display("[TB] FAIL sweep_model t=%0t pwm_out=%h exp=%h ps=%b exp=%b", $time, pwm_out, m_pwm, period_start, m_ps);
        end
        highs += int'(pwm_out[0] === 1'b1);
      end
      checks++;
      if (highs != exp_highs(duties[k])) begin
        errors++;
        $display("[TB] FAIL sweep_duty duty=%0d high cycles %0d, wanted %0d", duties[k], highs, exp_highs(duties[k]));
      end
    end
  endtask

  task automatic test_double_buffer();
    int seen;
    int highs;
    bit found;
    apply_write(3, 200);
    seen = 0;
    for (int n = 0; n < 3 * PERIOD && seen < 2; n++) begin
      @(negedge clk);
      checks++;
      if (pwm_out !== m_pwm || period_start !== m_ps) begin
        errors++;
        $display("[TB] FAIL dbuf_model t=%0t pwm_out=%h exp=%h ps=%b exp=%b", $time, pwm_out, m_pwm, period_start, m_ps);
      end
      if (period_start === 1'b1) seen++;
    end
    repeat (100) @(negedge clk);
    apply_write(3, 64);
    highs = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      highs += int'(pwm_out[3] === 1'b1);
    end
    checks++;
    if (highs != 50) begin
      errors++;
      $display("[TB] FAIL dbuf_old_duty high cycles %0d, wanted 50", highs);
    end
    found = 1'b0;
    for (int n = 0; n < 2 * PERIOD; n++) begin
      @(negedge clk);
      checks++;
      if (pwm_out !== m_pwm || period_start !== m_ps) begin
        errors++;
        $display("[TB] FAIL dbuf_model t=%0t pwm_out=%h exp=%h ps=%b exp=%b", $time, pwm_out, m_pwm, period_start, m_ps);
      end
      if (period_start === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    highs = 0;
    for (int n = 0; n < PERIOD; n++) begin
      @(negedge clk);
      highs += int'(pwm_out[3] === 1'b1);
    end
    checks++;
    if (!found || highs != exp_highs(64)) begin
      errors++;
      $display("[TB] FAIL dbuf_new_duty boundary=%0b high cycles %0d, wanted %0d", found, highs, exp_highs(64));
    end
    found = 1'b0;
    for (int n = 0; n < PERIOD + 2; n++) begin
      if (wrap_next()) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    apply_write(3, 10);
    checks++;
    if (!found || period_start !== 1'b1) begin
      errors++;
      $display("[TB] FAIL dbuf_wrap_write boundary found=%0b period_start=%b, wanted 1/1", found, period_start);
    end
    highs = 0;
    for (int n = 0; n < PERIOD; n++) begin
      @(negedge clk);
      highs += int'(pwm_out[3] === 1'b1);
    end
    checks++;
    if (highs != exp_highs(64)) begin
      errors++;
      $display("[TB] FAIL dbuf_wrap_delay high cycles %0d, wanted %0d", highs, exp_highs(64));
    end
    highs = 0;
    for (int n = 0; n < PERIOD; n++) begin
      @(negedge clk);
      checks++;
      if (pwm_out !== m_pwm || period_start !== m_ps) begin
        errors++;
        $display("[TB] FAIL dbuf_model t=%0t pwm_out=%h exp=%h ps=%b exp=%b", $time, pwm_out, m_pwm, period_start, m_ps);
      end
      highs += int'(pwm_out[3] === 1'b1);
    end
    checks++;
    if (highs != exp_highs(10)) begin
      errors++;
      $display("[TB] FAIL dbuf_wrap_apply high cycles %0d, wanted %0d", highs, exp_highs(10));
    end
  endtask

  task automatic test_prescaler();
    int seen;
    int gap;
    bit found;
    prescale = PRESC_W'(3);
    seen = 0;
    gap = 0;
    for (int n = 0; n < 10 * PERIOD && seen < 2; n++) begin
      @(negedge clk);
      checks++;
      if (pwm_out !== m_pwm || period_start !== m_ps) begin
        errors++;
        $display("[TB] FAIL presc_model t=%0t pwm_out=%h exp=%h ps=%b exp=%b", $time, pwm_out, m_pwm, period_start, m_ps);
      end
      if (seen == 1) gap++;
      if (period_start === 1'b1) seen++;
    end
    checks++;
    if (seen != 2 || gap != 4 * PERIOD) begin
      errors++;
      $display("[TB] FAIL presc_period pulses=%0d gap=%0d cycles, wanted 2 and %0d", seen, gap, 4 * PERIOD);
    end
    prescale = PRESC_W'(9);
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      checks++;
      if (pwm_out !== m_pwm || period_start !== m_ps) begin
        errors++;
        $display("[TB] FAIL presc_model t=%0t pwm_out=%h exp=%h ps=%b exp=%b", $time, pwm_out, m_pwm, period_start, m_ps);
      end
      if (m_pdiv == 7) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found || dut.u_presc.tick !== 1'b0) begin
      errors++;
      $display("[TB] FAIL presc_hold reached=%0b tick=%b, wanted 1/0", found, dut.u_presc.tick);
    end
    prescale = PRESC_W'(2);
    #1;
    checks++;
    if (dut.u_presc.tick !== 1'b1) begin
      errors++;
      $display("[TB] FAIL presc_lower tick=%b, wanted 1", dut.u_presc.tick);
    end
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      checks++;
      if (pwm_out !== m_pwm || period_start !== m_ps) begin
        errors++;
        $display("[TB] FAIL presc_model t=%0t pwm_out=%h exp=%h ps=%b exp=%b", $time, pwm_out, m_pwm, period_start, m_ps);
      end
    end
    prescale = '0;
  endtask

  task automatic test_enables();
    int seen;
    apply_write(5, 128);
    en_out[5] = 1'b0;
    en_pwm[5] = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      checks++;
      if (pwm_out[5] !== 1'b0 || pwm_out !== m_pwm) begin
        errors++;
        $display("[TB] FAIL en_out_off pwm_out=%h exp=%h, bit5 wanted 0", pwm_out, m_pwm);
      end
    end
    en_out[5] = 1'b1;
    en_pwm[5] = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      checks++;
      if (pwm_out[5] !== 1'b1 || pwm_out !== m_pwm) begin
        errors++;
        $display("[TB] FAIL en_static_high pwm_out=%h exp=%h, bit5 wanted 1", pwm_out, m_pwm);
      end
    end
    en_pwm[5] = 1'b1;
    for (int a = NUM_CH; a < (1 << ADDR_W); a++) begin
      apply_write(a, int'($urandom_range(1, MAXV)));
    end
    seen = 0;
    for (int n = 0; n < 3 * PERIOD && seen < 2; n++) begin
      @(negedge clk);
      checks++;
      if (pwm_out !== m_pwm || period_start !== m_ps) begin
        errors++;
        $display("[TB] FAIL en_model t=%0t pwm_out=%h exp=%h ps=%b exp=%b", $time, pwm_out, m_pwm, period_start, m_ps);
      end
      if (period_start === 1'b1) seen++;
    end
  endtask

`ifdef PWM_CENTER_ALIGNED_EN
  task automatic test_center();
    int seen;
    int gap;
    int highs;
    int rises;
    logic prev;
    prescale = '0;
    en_out = '1;
    en_pwm = '1;
    apply_write(1, 100);
    seen = 0;
    gap = 0;
    for (int n = 0; n < 4 * PERIOD && seen < 3; n++) begin
      @(negedge clk);
      checks++;
      if (pwm_out !== m_pwm || period_start !== m_ps) begin
        errors++;
        $display("[TB] FAIL center_model t=%0t pwm_out=%h exp=%h ps=%b exp=%b", $time, pwm_out, m_pwm, period_start, m_ps);
      end
      if (seen == 2) gap++;
      if (period_start === 1'b1) seen++;
    end
    checks++;
    if (gap != 508) begin
      errors++;
      $display("[TB] FAIL center_period gap=%0d cycles, wanted 508", gap);
    end
    highs = 0;
    rises = 0;
    prev = 1'b1;
    for (int n = 0; n < PERIOD; n++) begin
      @(negedge clk);
      highs += int'(pwm_out[1] === 1'b1);
      if (n > 0 && prev === 1'b0 && pwm_out[1] === 1'b1) rises++;
      prev = pwm_out[1];
    end
    checks++;
    if (highs != 199 || rises != 1) begin
      errors++;
      $display("[TB] FAIL center_pulse high=%0d rises=%0d, wanted 199 and 1", highs, rises);
    end
  endtask
`endif

  task automatic test_back_to_back();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      checks++;
      if (pwm_out !== m_pwm || period_start !== m_ps) begin
        errors++;
        $display("[TB] FAIL random_model t=%0t pwm_out=%h exp=%h ps=%b exp=%b", $time, pwm_out, m_pwm, period_start, m_ps);
      end
      wr_bus.wr_en   = ($urandom_range(0, 3) == 0);
      wr_bus.wr_addr = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
      wr_bus.wr_data = CNT_W'($urandom);
      if ($urandom_range(0, 63) == 0) en_out = NUM_CH'($urandom);
      if ($urandom_range(0, 63) == 0) en_pwm = NUM_CH'($urandom);
      if ($urandom_range(0, 255) == 0) prescale = PRESC_W'($urandom_range(0, 3));
      rst = ($urandom_range(0, 999) == 0);
    end
    wr_bus.wr_en = 1'b0;
    rst = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      checks++;
      if (pwm_out !== m_pwm || period_start !== m_ps) begin
        errors++;
        $display("[TB] FAIL random_tail t=%0t pwm_out=%h exp=%h ps=%b exp=%b", $time, pwm_out, m_pwm, period_start, m_ps);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    wr_bus.wr_en   = 1'b0;
    wr_bus.wr_addr = '0;
    wr_bus.wr_data = '0;
    test_reset();
    test_duty_sweep();
    test_double_buffer();
    test_prescaler();
    test_enables();
`ifdef PWM_CENTER_ALIGNED_EN
    test_center();
`endif
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
